// File: rtl/uart_rx_byte_if.sv
// Byte hand-off bus between the UART receiver and its consumer: data plus strobe/acknowledge.
interface uart_rx_byte_if;
  logic [7:0] rx_dat;
  logic       rx_stb;
  logic       rx_ack;

  modport master (output rx_dat, output rx_stb, input rx_ack);
  modport slave  (input rx_dat, input rx_stb, output rx_ack);
endinterface

// File: rtl/uart_rx_byte.sv
// UART receiver: synchronised 8N1 deserialiser with a one-entry holding register and strobe/ack hand-off.
// Define UART_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_rx_byte #(
  parameter int CLKS_PER_BIT = 1155,
  parameter int SYNC_STAGES  = 2
) (
  input  logic           CLK_133MHZ,
  input  logic           rst_n,
  input  logic           uart_rxd,
  uart_rx_byte_if.master rx_if,
  output logic           frame_err,
  output logic           overrun,
  output logic           parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT + SYNC_STAGES + 1);
  localparam logic [CW-1:0] C_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_MID    = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_SETTLE = CW'(SYNC_STAGES);

  typedef enum logic [2:0] {
    S_WAIT_IDLE, S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_rxs;
  state_t                 r_state, w_state_nxt;
  logic [CW-1:0]          r_baud, w_baud_nxt;
  logic [2:0]             r_bit, w_bit_nxt;
  logic [7:0]             r_shift;
  logic                   w_tick;
  logic                   w_sample_dat, w_good, w_ferr, w_perr;
  logic                   r_pend;
  logic [7:0]             r_dat;
  logic                   r_stb;
`ifdef UART_RX_PARITY_EN
  logic                   r_par;
`endif

  always_ff @(posedge CLK_133MHZ or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[SYNC_STAGES-2:0], uart_rxd};
  end

  assign w_rxs  = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_baud == C_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_bit_nxt    = r_bit;
    w_baud_nxt   = r_baud + CW'(1);
    w_sample_dat = 1'b0;
    w_good       = 1'b0;
    w_ferr       = 1'b0;
    w_perr       = 1'b0;
    case (r_state)
      // The synchroniser powers up all-ones, so demand the line be seen high
      // for longer than the chain depth before arming start-bit detection.
      S_WAIT_IDLE: if (w_rxs && r_baud == C_SETTLE) w_state_nxt = S_IDLE;
      S_IDLE:      if (!w_rxs) w_state_nxt = S_START;
      S_START: begin
        if (r_baud == C_MID) begin
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
            w_bit_nxt   = 3'd0;
          end
        end
      end
      S_DATA: begin
        if (w_tick) begin
          w_sample_dat = 1'b1;
          w_bit_nxt    = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
      end
      S_PARITY: if (w_tick) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_tick) begin
`ifdef UART_RX_PARITY_EN
          w_perr = ^{r_shift, r_par};
`endif
          if (w_rxs) begin
            w_state_nxt = S_IDLE;
            w_good      = !w_perr;
          end else begin
            w_state_nxt = S_WAIT_IDLE;
            w_ferr      = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_WAIT_IDLE;
    endcase

    if (w_state_nxt != r_state)       w_baud_nxt = '0;
    else if (r_state == S_WAIT_IDLE)  w_baud_nxt = w_rxs ? r_baud + CW'(1) : '0;
    else if (w_tick)                  w_baud_nxt = '0;
  end

  always_ff @(posedge CLK_133MHZ) begin
    if (w_sample_dat) r_shift[r_bit] <= w_rxs;
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge CLK_133MHZ) begin
    if (r_state == S_PARITY && w_tick) r_par <= w_rxs;
  end
`endif

  always_ff @(posedge CLK_133MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_WAIT_IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_pend     <= 1'b0;
      r_dat      <= '0;
      r_stb      <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_baud     <= w_baud_nxt;
      r_bit      <= w_bit_nxt;
      r_pend     <= w_good;
      frame_err  <= w_ferr;
      parity_err <= w_perr;
      overrun    <= r_pend && r_stb && !rx_if.rx_ack;
      // An ack in the hand-off cycle frees the holding register for the new byte.
      if (r_pend && (!r_stb || rx_if.rx_ack)) begin
        r_dat <= r_shift;
        r_stb <= 1'b1;
      end else if (r_stb && rx_if.rx_ack) begin
        r_stb <= 1'b0;
      end
    end
  end

  assign rx_if.rx_dat = r_dat;
  assign rx_if.rx_stb = r_stb;
endmodule
